// File: rtl/iv_pkg.sv
// Shared constants for the iv pipelined core: datapath width, reset vector
// and the opcode classes used by decode and execute.
package iv_pkg;

    localparam int          IV_XLEN     = 32;
    localparam int          IV_DEPTH    = 4;
    localparam logic [31:0] IV_RESET_PC = 32'd0;

    typedef enum logic [1:0] {
        AR_TYPE = 2'd0,
        M_TYPE  = 2'd1,
        BR_TYPE = 2'd2,
        SH_TYPE = 2'd3
    } op_class_e;

endpackage

// File: rtl/iv_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; pointers and count reset
// asynchronously, storage is left unreset.
module iv_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        rdata   = mem_q[rd_ptr_q];
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Flush wins over any push or pop in the same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/iv_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order
// responses into a prefetch queue, redirect flushes queued and in-flight words.
module iv_fetch_unit
    import iv_pkg::*;
#(
    parameter int              DEPTH    = IV_DEPTH,
    parameter int              XLEN     = IV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IV_RESET_PC)
) (
    input  logic            clk,
    input  logic            RN,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    input  logic            if_id_ready,
    output logic [XLEN-1:0] IF_ID_IR,
    output logic [XLEN-1:0] IF_ID_NPC
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW:0]       credit;
    logic              req_fire;
    logic              rsp_fire;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] fifo_wdata;
    logic [2*XLEN-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Outstanding requests include those already marked for discard, so a
    // request only goes out when a queue slot is guaranteed for its word.
    always_comb begin
        credit         = {1'b0, outstanding_q} + {1'b0, fifo_count};
        imem_req_valid = RN && !redirect_valid && (credit < DEPTH_C);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = imem_rsp_valid && (outstanding_q != '0);

        if_id_valid = !fifo_empty && !redirect_valid;
        IF_ID_IR    = fifo_empty ? '0 : fifo_rdata[2*XLEN-1:XLEN];
        IF_ID_NPC   = fifo_empty ? '0 : fifo_rdata[XLEN-1:0];
        pop         = if_id_valid && if_id_ready;

        push       = rsp_fire && (discard_q == '0) && !redirect_valid && (!fifo_full || pop);
        fifo_wdata = {imem_rsp_data, rsp_pc_q + XLEN'(1)};
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(1);
        end
        if (req_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!req_fire && rsp_fire) begin
            outstanding_d = outstanding_q - CW'(1);
        end
        if (rsp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + XLEN'(1);
        end

        // No request fires during a redirect, so everything still in flight
        // after this cycle's response belongs to the abandoned path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    iv_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clk   (clk),
        .rst_n (RN),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_iv_fetch_unit.sv
// Directed bench for iv_fetch_unit: behavioural in-order instruction memory,
// a per-cycle vector table for reset release, and hand-written corner cases.
module tb_iv_fetch_unit;

    logic        clk = 1'b0;
    logic        RN;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic        if_id_ready;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_NPC;

    iv_fetch_unit #(
        .DEPTH    (4),
        .XLEN     (32),
        .RESET_PC (32'd0)
    ) dut (
        .clk            (clk),
        .RN             (RN),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_ready    (if_id_ready),
        .IF_ID_IR       (IF_ID_IR),
        .IF_ID_NPC      (IF_ID_NPC)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic        dec_ready;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_if_valid;
        logic [31:0] exp_ir;
        logic [31:0] exp_npc;
    } vec_t;

    req_t        mq[$];
    vec_t        vecs[6];
    int          total_count = 0;
    int          pass_count  = 0;
    int          cyc         = 0;
    int          issued      = 0;
    int          decoded     = 0;
    logic [31:0] exp_addr    = 32'd0;
    bit          ready_random, ready_value, dec_random, dec_value;
    bit          rsp_force, redir_v, rn_value;
    int          lat_min, lat_max;
    logic [31:0] redir_pc;

    // Memory contents: the four given words, then a recognisable pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   mem_word = 32'h02208300;
            32'd1:   mem_word = 32'h02209380;
            32'd2:   mem_word = 32'h0230a400;
            32'd3:   mem_word = 32'h02513480;
            default: mem_word = {8'hC0, a[23:0]};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_val);
        total_count++;
        if (act === exp_val) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_val);
    endtask

    // One cycle: drive inputs at negedge, settle, then account for the
    // handshakes that the next rising edge will complete.
    task automatic applyStimulus();
        bit rsp_now;
        int lat;
        int due;
        @(negedge clk);
        cyc++;
        RN             = rn_value;
        imem_req_ready = ready_random ? ($urandom_range(0, 1) == 1) : ready_value;
        if_id_ready    = dec_random ? ($urandom_range(0, 3) != 0) : dec_value;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc;
        rsp_now        = 1'b0;
        if (rsp_force) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEADBEEF;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            rsp_now        = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
        #1;
        if (rsp_now) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + lat;
            if (mq.size() > 0 && due < mq[$].due) due = mq[$].due;
            mq.push_back('{addr: imem_req_addr, due: due});
            issued++;
        end
        if (redirect_valid) exp_addr = redirect_pc;
        if (if_id_valid && if_id_ready) begin
            checkOutput("decode_ir", IF_ID_IR, mem_word(exp_addr));
            checkOutput("decode_npc", IF_ID_NPC, exp_addr + 32'd1);
            exp_addr = exp_addr + 32'd1;
            decoded++;
        end
    endtask

    task automatic do_reset();
        RN             = 1'b0;
        rn_value       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if_id_ready    = 1'b0;
        redir_v        = 1'b0;
        rsp_force      = 1'b0;
        ready_random   = 1'b0;
        dec_random     = 1'b0;
        mq.delete();
        #1;
        checkOutput("reset_req_valid", imem_req_valid, 32'd0);
        checkOutput("reset_if_valid", if_id_valid, 32'd0);
        checkOutput("reset_ir", IF_ID_IR, 32'd0);
        checkOutput("reset_npc", IF_ID_NPC, 32'd0);
        repeat (2) @(negedge clk);
        exp_addr = 32'd0;
        rn_value = 1'b1;
    endtask

    // Step until one more decode handshake happens or the budget runs out.
    task automatic wait_handshake(input string name, input int budget);
        int start;
        int n;
        start = decoded;
        n     = 0;
        while (decoded == start && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, decoded - start, 32'd1);
    endtask

    task automatic drain_to(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (decoded < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, decoded, target);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;

        vecs[0] = '{1'b1, 1'b1, 32'd0, 1'b0, 32'h00000000, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 32'd1, 1'b0, 32'h00000000, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 32'd2, 1'b1, 32'h02208300, 32'd1};
        vecs[3] = '{1'b1, 1'b1, 32'd3, 1'b1, 32'h02209380, 32'd2};
        vecs[4] = '{1'b1, 1'b1, 32'd4, 1'b1, 32'h0230a400, 32'd3};
        vecs[5] = '{1'b1, 1'b1, 32'd5, 1'b1, 32'h02513480, 32'd4};

        RN       = 1'b1;
        redir_pc = 32'd0;
        lat_min  = 1;
        lat_max  = 1;
        #2;

        // Reset release with 1-cycle memory and an always-ready decoder.
        do_reset();
        ready_value = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dec_value = vecs[i].dec_ready;
            applyStimulus();
            checkOutput("t1_req_valid", imem_req_valid, vecs[i].exp_req_valid);
            checkOutput("t1_req_addr", imem_req_addr, vecs[i].exp_req_addr);
            checkOutput("t1_if_valid", if_id_valid, vecs[i].exp_if_valid);
            if (vecs[i].exp_if_valid) begin
                checkOutput("t1_ir", IF_ID_IR, vecs[i].exp_ir);
                checkOutput("t1_npc", IF_ID_NPC, vecs[i].exp_npc);
            end
        end

        // Decoder stalls for 10 cycles: only DEPTH requests may go out.
        do_reset();
        ready_value = 1'b1;
        dec_value   = 1'b0;
        start       = issued;
        repeat (10) applyStimulus();
        checkOutput("t2_issued", issued - start, 32'd4);
        checkOutput("t2_req_valid", imem_req_valid, 32'd0);
        checkOutput("t2_head_valid", if_id_valid, 32'd1);
        checkOutput("t2_head_ir", IF_ID_IR, 32'h02208300);
        dec_value = 1'b1;
        drain_to("t2_drain", decoded + 12, 80);

        // Redirect to 25 with three requests in flight.
        do_reset();
        ready_value = 1'b1;
        dec_value   = 1'b1;
        lat_min     = 10;
        lat_max     = 10;
        start       = issued;
        repeat (3) applyStimulus();
        checkOutput("t3_inflight", issued - start, 32'd3);
        redir_v  = 1'b1;
        redir_pc = 32'd25;
        applyStimulus();
        checkOutput("t3_redir_req_valid", imem_req_valid, 32'd0);
        checkOutput("t3_redir_if_valid", if_id_valid, 32'd0);
        redir_v = 1'b0;
        lat_min = 1;
        lat_max = 1;
        applyStimulus();
        checkOutput("t3_req_valid", imem_req_valid, 32'd1);
        checkOutput("t3_req_addr", imem_req_addr, 32'd25);
        wait_handshake("t3_first_seen", 40);
        checkOutput("t3_first_ir", IF_ID_IR, 32'hC0000019);
        checkOutput("t3_first_npc", IF_ID_NPC, 32'd26);

        // Redirect colliding with a response and a decode handshake.
        do_reset();
        ready_value = 1'b1;
        dec_value   = 1'b1;
        repeat (3) applyStimulus();
        redir_v  = 1'b1;
        redir_pc = 32'd40;
        applyStimulus();
        checkOutput("t4_if_valid", if_id_valid, 32'd0);
        checkOutput("t4_req_valid", imem_req_valid, 32'd0);
        redir_v = 1'b0;
        applyStimulus();
        checkOutput("t4_req_addr", imem_req_addr, 32'd40);
        wait_handshake("t4_first_seen", 20);
        checkOutput("t4_first_ir", IF_ID_IR, 32'hC0000028);
        checkOutput("t4_first_npc", IF_ID_NPC, 32'd41);

        // Random memory readiness and latency; stream must stay sequential.
        do_reset();
        ready_random = 1'b1;
        dec_random   = 1'b1;
        lat_min      = 1;
        lat_max      = 4;
        start        = decoded;
        repeat (400) applyStimulus();
        checkOutput("t5_progress", (decoded - start) >= 40, 32'd1);
        ready_random = 1'b0;
        dec_random   = 1'b0;
        lat_min      = 1;
        lat_max      = 1;

        // Reset pulled while the queue holds three entries.
        do_reset();
        ready_value = 1'b1;
        dec_value   = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("t6_pre_valid", if_id_valid, 32'd1);
        checkOutput("t6_pre_ir", IF_ID_IR, 32'h02208300);
        do_reset();
        ready_value = 1'b1;
        dec_value   = 1'b1;
        applyStimulus();
        checkOutput("t6_restart_valid", imem_req_valid, 32'd1);
        checkOutput("t6_restart_addr", imem_req_addr, 32'd0);
        drain_to("t6_drain", decoded + 4, 20);

        // Stray responses with nothing outstanding must be ignored.
        do_reset();
        ready_value = 1'b0;
        dec_value   = 1'b1;
        rsp_force   = 1'b1;
        repeat (2) applyStimulus();
        rsp_force = 1'b0;
        applyStimulus();
        checkOutput("t7_if_valid", if_id_valid, 32'd0);
        ready_value = 1'b1;
        wait_handshake("t7_first_seen", 20);
        checkOutput("t7_first_ir", IF_ID_IR, 32'h02208300);
        checkOutput("t7_first_npc", IF_ID_NPC, 32'd1);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
